avalon_read_master: RTL
=======================

# avalon_read_master

Avalon-MM read master that sits directly downstream of the read-request gating stage in the RISC-V memory path. Takes the gated single-request read strobe plus address and load type from the core, performs one Avalon-MM pipelined read (waitrequest + readdatavalid), aligns and sign/zero-extends the returned word per RISC-V load semantics, and returns a one-cycle `Done` pulse. It never issues a new bus read until the previous one has completed with `Done`.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in REQ+WAIT_DATA before abort; used only when the timeout is compiled in (see Configuration).
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `RRead`  in  1  read request from the gating stage; sampled only in IDLE.
- `RAddr`  in  32  byte address; latched with `RRead`.
- `RFunct3`  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; latched with `RRead`.
- `Done`  out  1  one-cycle completion pulse.
- `RData`  out  32  extracted load result; held until the next completion.
- `RErr`  out  1  error flag, valid with `Done`.
- `avm_address`  out  32  word address, `{addr[31:2], 2'b00}`.
- `avm_byteenable`  out  4  lanes selected by size and `addr[1:0]`.
- `avm_read`  out  1  Avalon read strobe.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data qualifier.

## Operation
- States: IDLE, REQ, WAIT_DATA, DONE.
- IDLE with `RRead`=1:
  - Latch address and funct3.
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with error.
- Illegal or misaligned means any of:
  - funct3 is 3, 6 or 7;
  - LH/LHU with `addr[0]`=1;
  - LW with `addr[1:0]`≠0.
- REQ:
  - `avm_read`=1 and address/byteenable stable.
  - Stay while `avm_waitrequest`=1.
  - On acceptance (`avm_waitrequest`=0), go to WAIT_DATA.
- WAIT_DATA:
  - `avm_read`=0.
  - On `avm_readdatavalid`, capture the extracted data into `RData`, clear `RErr`, go to DONE.
- `avm_readdatavalid` outside WAIT_DATA is ignored.
- DONE: `Done`=1 for exactly one cycle, then IDLE. `RRead` seen in DONE is ignored.
- Byteenable:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Extraction, with lane = `addr[1:0]`:
  - LB/LBU: `readdata[8*lane +: 8]`, sign- or zero-extended to 32 bits.
  - LH/LHU: `readdata[8*lane +: 16]`, sign- or zero-extended.
  - LW: passthrough.
- Error completion: `RData`=0, `RErr`=1, no bus access.
- Reset values:
  - state IDLE;
  - `Done`, `RErr`, `avm_read`=0;
  - `RData`, `avm_address`, `avm_byteenable`=0.
- Reset mid-transaction: the bus read is dropped immediately and asynchronously.

## Timing
- All outputs are registered.
- `RRead` in cycle N:
  - `avm_read` high from N+1.
  - With zero wait: accepted at N+1; `readdatavalid` earliest N+2; `Done` and `RData` at N+3.
- Each waitrequest cycle or readdatavalid delay cycle adds one cycle.
- Error path: `Done`=1 at N+1.
- `Done` is never asserted in two consecutive cycles.
- `RData` and `RErr` remain stable after `Done` until the next completion.

## Configuration
- `AVALON_READ_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on IDLE→REQ and increments every cycle in REQ or WAIT_DATA.
  - When it reaches `TIMEOUT_CYCLES`: drop `avm_read`, go to DONE with `RErr`=1 and `RData`=0.
  - A late `readdatavalid` arriving after the abort is ignored.
- Undefined:
  - No counter; the block waits indefinitely.
  - `RErr` is raised only for illegal or misaligned requests.

## Structure
- Package `avalon_read_pkg` holds:
  - state enum;
  - funct3 load constants (LB, LH, LW, LBU, LHU);
  - `TIMEOUT_CYCLES` default.
- Sub-module `load_align` (combinational) takes funct3, `addr[1:0]` and readdata, and produces byteenable, misaligned/illegal flag and extended data.
- The top level holds the FSM, the latches and the optional counter.

## Test plan
- LW addr 0x100, no wait, readdata 0xDEADBEEF at N+2 -> `avm_address` 0x100, byteenable 0xF at N+1; `Done`=1 at N+3, `RData`=0xDEADBEEF, `RErr`=0.
- LB addr 0x103, readdata 0x80112233 -> byteenable 0x8, `RData`=0xFFFFFF80. LBU same stimulus -> `RData`=0x00000080.
- LH addr 0x102, waitrequest high 3 cycles, readdata 0x7FFE0000 -> `avm_read` held 4 cycles, byteenable 0xC, `RData`=0x00007FFE, `Done` at N+6.
- LW addr 0x101 -> no `avm_read`, `Done`=1 at N+1, `RErr`=1, `RData`=0. funct3=3 gives the same response.
- `RST_N` low while in WAIT_DATA -> `avm_read`/`Done`/`RData` all 0 immediately; a later stale `readdatavalid` produces no `Done`.
- With `AVALON_READ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, readdatavalid never asserted -> `Done`=1 with `RErr`=1 and `RData`=0 five cycles after acceptance into REQ.

Source files
------------

// File: rtl/avalon_read_pkg.sv
// Shared types and constants for the Avalon-MM read master and its load alignment helper.
package avalon_read_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StWaitData, StDone} state_e;

   localparam logic [2:0] F3Lb  = 3'd0;
   localparam logic [2:0] F3Lh  = 3'd1;
   localparam logic [2:0] F3Lw  = 3'd2;
   localparam logic [2:0] F3Lbu = 3'd4;
   localparam logic [2:0] F3Lhu = 3'd5;

   localparam int unsigned TimeoutCyclesDefault = 255;

endpackage

// File: rtl/load_align.sv
// RISC-V load lane decode: byteenable, illegal/misaligned detection and data extension.
module load_align
   import avalon_read_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] readdata_i,
   output logic [3:0]  byteenable_o,
   output logic        bad_o,
   output logic [31:0] data_o
);

   logic [15:0] shifted;

   assign shifted = 16'(readdata_i >> {lane_i, 3'b000});

   always_comb begin
      byteenable_o = 4'b0000;
      bad_o        = 1'b0;
      data_o       = readdata_i;
      unique case (funct3_i)
         F3Lb, F3Lbu: begin
            byteenable_o = 4'b0001 << lane_i;
            data_o       = {{24{shifted[7] & (funct3_i == F3Lb)}}, shifted[7:0]};
         end
         F3Lh, F3Lhu: begin
            byteenable_o = 4'b0011 << lane_i;
            bad_o        = lane_i[0];
            data_o       = {{16{shifted[15] & (funct3_i == F3Lh)}}, shifted[15:0]};
         end
         F3Lw: begin
            byteenable_o = 4'b1111;
            bad_o        = |lane_i;
         end
         default: bad_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/avalon_read_master.sv
// Single-outstanding Avalon-MM read master with RISC-V load alignment.
// Optional request timeout compiled in with AVALON_READ_TIMEOUT_EN.
module avalon_read_master
   import avalon_read_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        RRead,
   input  logic [31:0] RAddr,
   input  logic [2:0]  RFunct3,
   output logic        Done,
   output logic [31:0] RData,
   output logic        RErr,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid
);

   state_e      state_q;
   logic [1:0]  lane_q;
   logic [2:0]  funct3_q;
   logic        done_q;
   logic [31:0] rdata_q;
   logic        rerr_q;
   logic        read_q;
   logic [31:0] address_q;
   logic [3:0]  be_q;

   logic        idle;
   logic [3:0]  al_be;
   logic        al_bad;
   logic [31:0] al_data;
   logic        timeout_hit;

   assign idle = (state_q == StIdle);

   // Decode the incoming request while idle, the latched one while the read is in flight.
   load_align u_load_align (
      .funct3_i     (idle ? RFunct3 : funct3_q),
      .lane_i       (idle ? RAddr[1:0] : lane_q),
      .readdata_i   (avm_readdata),
      .byteenable_o (al_be),
      .bad_o        (al_bad),
      .data_o       (al_data)
   );

`ifdef AVALON_READ_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (idle && RRead) begin
         cnt_d = '0;
      end else if (state_q == StReq || state_q == StWaitData) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign timeout_hit = (32'(cnt_q) >= TIMEOUT_CYCLES);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         lane_q    <= 2'b00;
         funct3_q  <= 3'b000;
         done_q    <= 1'b0;
         rdata_q   <= 32'h0;
         rerr_q    <= 1'b0;
         read_q    <= 1'b0;
         address_q <= 32'h0;
         be_q      <= 4'h0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (RRead) begin
                  lane_q   <= RAddr[1:0];
                  funct3_q <= RFunct3;
                  if (al_bad) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     rdata_q <= 32'h0;
                     rerr_q  <= 1'b1;
                  end else begin
                     state_q   <= StReq;
                     read_q    <= 1'b1;
                     address_q <= {RAddr[31:2], 2'b00};
                     be_q      <= al_be;
                  end
               end
            end
            StReq: begin
               if (timeout_hit) begin
                  read_q  <= 1'b0;
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  rdata_q <= 32'h0;
                  rerr_q  <= 1'b1;
               end else if (!avm_waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= StWaitData;
               end
            end
            StWaitData: begin
               // Data arriving on the timeout cycle still wins over the abort.
               if (avm_readdatavalid) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  rdata_q <= al_data;
                  rerr_q  <= 1'b0;
               end else if (timeout_hit) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  rdata_q <= 32'h0;
                  rerr_q  <= 1'b1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign Done           = done_q;
   assign RData          = rdata_q;
   assign RErr           = rerr_q;
   assign avm_read       = read_q;
   assign avm_address    = address_q;
   assign avm_byteenable = be_q;

endmodule
